// File: rtl/sipo_deser_pkg.sv
// Shared constants for the serial-to-parallel deserialiser.
package sipo_deser_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width: enough to hold 0..width-1, never narrower than one bit.
  function automatic int cnt_width(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input / parallel output bundle for sipo_deser.
interface sipo_deser_if
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int CW = cnt_width(WIDTH);

  logic             in;
  logic             in_valid;
  logic             clr;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;

  modport master (
    output in, in_valid, clr, out_ready,
    input  out, out_valid, bit_cnt, overrun
  );

  modport slave (
    input  in, in_valid, clr, out_ready,
    output out, out_valid, bit_cnt, overrun
  );
endinterface

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter; wrap flags the bit that completes a frame.
module sipo_bit_counter
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          wrap
);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;

  assign wrap = en & (cnt_q == LAST);
  assign cnt  = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserialiser with a one-word valid/ready output
// holding register and a sticky overrun flag.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  sipo_deser_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             overrun_q;
  logic             accept;
  logic             wrap;
  logic [CW-1:0]    cnt;

  // clr wins over in_valid: a bit offered alongside clr is dropped.
  assign accept = bus.in_valid & ~bus.clr;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_nxt = {shift_q[WIDTH-2:0], bus.in};
    end else begin : g_lsb
      assign shift_nxt = {bus.in, shift_q[WIDTH-1:1]};
    end
  endgenerate

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .clr  (bus.clr),
    .cnt  (cnt),
    .wrap (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (bus.clr) begin
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (accept) begin
        shift_q <= shift_nxt;
      end
      // A completing word may replace the held one only if the slot is free
      // or being drained on this same edge; otherwise it is lost.
      if (wrap) begin
        if (!out_valid_q || bus.out_ready) begin
          out_q       <= shift_nxt;
          out_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bit_cnt   = cnt;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: one MSB-first and one LSB-first instance
// share stimulus and are checked against a bit-queue reference model.
module tb_sipo_deser;
  import sipo_deser_pkg::*;

  localparam int W  = DEFAULT_WIDTH;
  localparam int CW = cnt_width(W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_in = 1'b0, d_vld = 1'b0, d_clr = 1'b0, d_rdy = 1'b0;

  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(W)) bus_m ();
  sipo_deser_if #(.WIDTH(W)) bus_l ();

  assign bus_m.in = d_in;  assign bus_m.in_valid = d_vld;
  assign bus_m.clr = d_clr; assign bus_m.out_ready = d_rdy;
  assign bus_l.in = d_in;  assign bus_l.in_valid = d_vld;
  assign bus_l.clr = d_clr; assign bus_l.out_ready = d_rdy;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  int checks = 0;
  int failures = 0;

  // Reference model: bits of the partial frame in arrival order.
  logic         bits[$];
  logic [W-1:0] m_out_m = '0, m_out_l = '0;
  logic         m_vld = 1'b0, m_ovr = 1'b0;
  logic [W-1:0] exp_m[$], exp_l[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] form_word(input bit msb_first);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb_first) w[W-1-i] = bits[i];
      else           w[i]     = bits[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    bits.delete();
    m_out_m = '0; m_out_l = '0;
    m_vld = 1'b0; m_ovr = 1'b0;
    exp_m.delete(); exp_l.delete();
  endtask

  task automatic model_edge();
    logic [W-1:0] wm, wl;
    logic xfer;
    if (d_clr) begin
      bits.delete();
      m_vld = 1'b0; m_ovr = 1'b0;
      exp_m.delete(); exp_l.delete();
    end else begin
      xfer = m_vld && d_rdy;
      if (d_vld) bits.push_back(d_in);
      if (bits.size() == W) begin
        wm = form_word(1'b1);
        wl = form_word(1'b0);
        bits.delete();
        if (!m_vld || d_rdy) begin
          m_out_m = wm; m_out_l = wl; m_vld = 1'b1;
          exp_m.push_back(wm); exp_l.push_back(wl);
        end else begin
          m_ovr = 1'b1;
        end
      end else if (xfer) begin
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic check_state();
    chk("out_m", bus_m.out, m_out_m);
    chk("out_l", bus_l.out, m_out_l);
    chk("out_valid_m", bus_m.out_valid, m_vld);
    chk("out_valid_l", bus_l.out_valid, m_vld);
    chk("bit_cnt_m", bus_m.bit_cnt, bits.size());
    chk("bit_cnt_l", bus_l.bit_cnt, bits.size());
    chk("overrun_m", bus_m.overrun, m_ovr);
    chk("overrun_l", bus_l.overrun, m_ovr);
  endtask

  // Called at posedge+1: drive inputs, let one edge pass, compare.
  task automatic cycle(input logic i, input logic v, input logic c, input logic r);
    d_in = i; d_vld = v; d_clr = c; d_rdy = r;
    @(posedge clk);
    model_edge();
    #1;
    check_state();
  endtask

  task automatic send_word(input logic [W-1:0] seq, input logic rdy, input logic last_rdy);
    for (int i = 0; i < W; i++)
      cycle(seq[W-1-i], 1'b1, 1'b0, (i == W-1) ? last_rdy : rdy);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_out_m"}, bus_m.out, 0);
    chk({tag, "_out_l"}, bus_l.out, 0);
    chk({tag, "_valid"}, bus_m.out_valid | bus_l.out_valid, 0);
    chk({tag, "_cnt"}, bus_m.bit_cnt | bus_l.bit_cnt, 0);
    chk({tag, "_ovr"}, bus_m.overrun | bus_l.overrun, 0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear before any edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 zero_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a word transfers on the coming edge.
  always @(negedge clk) begin
    if (!rst && !d_clr && d_rdy) begin
      if (bus_m.out_valid) begin
        if (exp_m.size() == 0) chk("sb_m_empty", 1, 0);
        else chk("sb_m", bus_m.out, exp_m.pop_front());
      end
      if (bus_l.out_valid) begin
        if (exp_l.size() == 0) chk("sb_l_empty", 1, 0);
        else chk("sb_l", bus_l.out, exp_l.pop_front());
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    zero_outputs("reset_state");
    rst = 1'b0;

    // Basic word, both bit orders, held with out_ready=0.
    send_word(8'b1100_0000, 1'b0, 1'b0);
    chk("word_msb", bus_m.out, 8'hC0);
    chk("word_lsb", bus_l.out, 8'h03);
    chk("word_valid", bus_m.out_valid, 1);
    chk("word_cnt", bus_m.bit_cnt, 0);

    // Overrun: second word dropped while the first is held.
    send_word(8'b1010_1010, 1'b0, 1'b0);
    chk("ovr_hold", bus_m.out, 8'hC0);
    chk("ovr_set", bus_m.overrun, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_drain_valid", bus_m.out_valid, 0);
    chk("ovr_sticky", bus_m.overrun, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_clr", bus_m.overrun, 0);

    // Gaps of in_valid=0 between bits: bit_cnt holds, same word results.
    for (int i = 0; i < W; i++) begin
      cycle(($urandom_range(0, 1) == 1), 1'b0, 1'b0, 1'b0);
      cycle((i < 2), 1'b1, 1'b0, 1'b0);
      cycle(($urandom_range(0, 1) == 1), 1'b0, 1'b0, 1'b0);
    end
    chk("gap_word", bus_m.out, 8'hC0);

    // Back-to-back: ready on the edge that completes the next word.
    send_word(8'b1111_0001, 1'b0, 1'b1);
    chk("b2b_msb", bus_m.out, 8'hF1);
    chk("b2b_lsb", bus_l.out, 8'h8F);
    chk("b2b_valid", bus_m.out_valid, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame, then a fresh word.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    async_reset();
    send_word(8'b0110_0101, 1'b0, 1'b0);
    chk("post_rst_word", bus_m.out, 8'h65);

    // Clear mid-frame, then a fresh word.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_cnt", bus_m.bit_cnt, 0);
    send_word(8'b0011_1100, 1'b1, 1'b1);
    chk("post_clr_word", bus_m.out, 8'h3C);

    // clr together with in_valid: the bit is not accepted.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_vld_cnt", bus_m.bit_cnt, 0);
    send_word(8'b1000_0001, 1'b0, 1'b0);
    chk("clr_vld_word", bus_m.out, 8'h81);
    chk("clr_vld_word_l", bus_l.out, 8'h81);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      else cycle($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 8: deserialised word width; SHALL be >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first received bit lands in out[WIDTH-1]; 0 = first received bit lands in out[0].
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in  input  1  serial data bit, sampled only when in_valid=1.
REQ-006 in_valid  input  1  qualifies in for the current cycle.
REQ-007 clr  input  1  synchronous frame resynchronise/clear.
REQ-008 out  output  WIDTH  last completed word, held stable while out_valid=1.
REQ-009 out_valid  output  1  a completed word is available on out.
REQ-010 out_ready  input  1  consumer accepts out this cycle when out_valid=1.
REQ-011 bit_cnt  output  CW  bits collected in the current partial frame, 0..WIDTH-1, where CW = max(1, clog2(WIDTH)).
REQ-012 overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 Each cycle with in_valid=1 and clr=0, the shift register SHALL take in the bit: MSB_FIRST=1 shifts left with in entering bit 0; MSB_FIRST=0 shifts right with in entering bit WIDTH-1.
REQ-014 bit_cnt SHALL increment on every accepted bit and wrap from WIDTH-1 to 0 on the bit that completes a frame.
REQ-015 Cycles with in_valid=0 SHALL leave the shift register and bit_cnt unchanged; there is no timeout.
REQ-016 Frame completion is an accepted bit while bit_cnt=WIDTH-1. The completed word SHALL include that bit.
REQ-017 Latency: out and out_valid SHALL update at the same edge that samples the completing bit.
REQ-018 Handshake: a word transfers on any edge where out_valid=1 and out_ready=1. out_valid SHALL clear after the transfer unless a new word completes on that same edge.
REQ-019 On completion with out_valid=0, or with out_valid=1 and out_ready=1, out SHALL load the new word and out_valid SHALL be 1.
REQ-020 On completion with out_valid=1 and out_ready=0:
- the new word SHALL be discarded;
- out SHALL keep the old word;
- overrun SHALL set.
REQ-021 overrun SHALL remain set until clr or rst; it SHALL have no effect on shifting or counting.
REQ-022 clr=1 SHALL zero the shift register, bit_cnt, out_valid and overrun on the next edge. out keeps its value.
REQ-023 clr SHALL have priority over in_valid and out_ready in the same cycle. A bit presented with clr=1 is not accepted.
REQ-024 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-025 While rst=1, all outputs and internal state SHALL be cleared immediately, independent of clk:
- out = 0;
- out_valid = 0;
- bit_cnt = 0;
- overrun = 0;
- shift register = 0.
REQ-026 Reset mid-frame SHALL discard the partial frame. The first accepted bit after deassertion SHALL be bit 1 of a new frame.

Structure
REQ-027 The shared constants package/include SHALL hold DEFAULT_WIDTH and the clog2-based counter-width function. No typedefs are required.
REQ-028 One sub-module, sipo_bit_counter, SHALL be used:
- modulo-WIDTH counter with enable, sync clear and async reset;
- wrap output marks the completing bit.
REQ-029 The shift register and output holding register SHALL be in sipo_deser itself.

Verification
REQ-030 WIDTH=8, MSB_FIRST=1: bits 1,1,0,0,0,0,0,0 on consecutive in_valid cycles with out_ready=0 -> out=8'hC0, out_valid=1 at the 8th-bit edge, bit_cnt=0.
REQ-031 WIDTH=8, MSB_FIRST=0: same bit sequence -> out=8'h03.
REQ-032 Gaps of in_valid=0 inserted between bits -> same word as REQ-030, and bit_cnt holds during the gaps.
REQ-033 Overrun case:
- first word 8'hC0 held with out_ready=0;
- second 8 bits sent;
- required: out stays 8'hC0, overrun=1;
- then out_ready=1 -> out_valid=0 next edge, overrun stays 1;
- then clr -> overrun=0.
REQ-034 Back-to-back: out_ready=1 on the same edge as the second word completes -> out switches to the new word and out_valid stays 1.
REQ-035 Reset and clear mid-frame:
- rst asserted asynchronously after 5 bits -> all outputs 0 immediately;
- the next 8 bits form a fresh word;
- repeat with clr, and with clr and in_valid asserted together: bit not accepted.
